// File: rtl/fns_enc_7_2.sv
// fns_enc_7_2 -- sequential Fibonacci-numeral-system encoder.
//
// The encoder turns a BLEN-bit binary word into an NBIT-bit FNS codeword.
// It subtracts greedily, MSB lane first, and settles one codeword bit per
// clock. Lane weights and per-lane enables are captured with the word, so
// the matching decoder stage can rebuild the data from the same values.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   data_in / en_flag / weights are valid
//   in_ready   encoder is idle and can accept a word
//   data_in    BLEN-bit binary word to encode
//   en_flag    NBIT per-lane enables; a disabled lane is never set
//   weights    NBIT*WLEN packed lane weights, lane i at [i*WLEN +: WLEN]
//              (the fields for lanes 0 and 1 are ignored; those lanes weigh 1)
//   out_valid  codeout / err are valid
//   out_ready  consumer accepts the output
//   codeout    NBIT-bit FNS codeword, bit i carries lane i's weight
//   err        remainder was not zero after lane 0 (word not representable)
module fns_enc_7_2 #(
  parameter int BLEN = 7,
  parameter int NBIT = 9,
  parameter int WLEN = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BLEN-1:0]      data_in,
  input  logic [NBIT-1:0]      en_flag,
  input  logic [NBIT*WLEN-1:0] weights,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NBIT-1:0]      codeout,
  output logic                 err
);

  localparam int IDXW  = $clog2(NBIT);
  localparam int NSLOT = 2 ** IDXW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [WLEN-1:0]        rem_reg, rem_next;
  logic [IDXW-1:0]        idx_reg, idx_next;
  logic [NBIT-1:0]        code_reg, code_next;
  logic                   err_reg, err_next;
  logic [NBIT-1:0]        en_reg, en_next;
  logic [NBIT*WLEN-1:0]   w_reg, w_next;
  logic                   in_ready_reg, in_ready_next;
  logic                   out_valid_reg, out_valid_next;

  // Per-lane effective weight and enable. The tables are padded to a power
  // of two so idx_reg can index them directly; the padded slots are never
  // reached because idx_reg only counts NBIT-1 down to 0.
  logic [WLEN-1:0]  lane_w [NSLOT];
  logic [NSLOT-1:0] lane_en;

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_lane
      if (gi < 2) begin : g_unit
        // Lanes 0 and 1 always weigh 1, whatever their weight field says.
        assign lane_w[gi]  = WLEN'(1);
        assign lane_en[gi] = en_reg[gi];
      end else if (gi < NBIT) begin : g_prog
        assign lane_w[gi]  = w_reg[gi*WLEN +: WLEN];
        assign lane_en[gi] = en_reg[gi];
      end else begin : g_pad
        assign lane_w[gi]  = '0;
        assign lane_en[gi] = 1'b0;
      end
    end
  endgenerate

  logic [WLEN-1:0] cur_w;
  logic            take;
  logic [WLEN-1:0] rem_after;

  // A lane is taken only when the remainder covers its weight, so the
  // subtraction cannot wrap. A weight of 0 on an enabled lane is always taken.
  assign cur_w     = lane_w[idx_reg];
  assign take      = lane_en[idx_reg] && (rem_reg >= cur_w);
  assign rem_after = take ? (rem_reg - cur_w) : rem_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rem_reg       <= '0;
      idx_reg       <= IDXW'(NBIT - 1);
      code_reg      <= '0;
      err_reg       <= 1'b0;
      en_reg        <= '0;
      w_reg         <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rem_reg       <= rem_next;
      idx_reg       <= idx_next;
      code_reg      <= code_next;
      err_reg       <= err_next;
      en_reg        <= en_next;
      w_reg         <= w_next;
      in_ready_reg  <= in_ready_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rem_next       = rem_reg;
    idx_next       = idx_reg;
    code_next      = code_reg;
    err_next       = err_reg;
    en_next        = en_reg;
    w_next         = w_reg;
    in_ready_next  = in_ready_reg;
    out_valid_next = out_valid_reg;

    unique case (state_reg)
      IDLE: begin
        if (in_valid) begin
          // Snapshot the whole word so that upstream changes cannot disturb it.
          rem_next      = WLEN'(data_in);
          en_next       = en_flag;
          w_next        = weights;
          idx_next      = IDXW'(NBIT - 1);
          code_next     = '0;
          err_next      = 1'b0;
          in_ready_next = 1'b0;
          state_next    = RUN;
        end
      end

      RUN: begin
        rem_next           = rem_after;
        code_next[idx_reg] = take;
        if (idx_reg == '0) begin
          err_next       = (rem_after != '0);
          out_valid_next = 1'b1;
          state_next     = DONE;
        end else begin
          idx_next = idx_reg - 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          in_ready_next  = 1'b1;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next     = IDLE;
        in_ready_next  = 1'b1;
        out_valid_next = 1'b0;
      end
    endcase
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign codeout   = code_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_fns_enc_7_2.sv
// Directed testbench for fns_enc_7_2. Inputs are driven 1 time unit after
// each rising edge, and outputs are sampled at that same point.
module tb_fns_enc_7_2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  data_in;
  logic [8:0]  en_flag;
  logic [62:0] weights;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  codeout;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;

  // Lane 8 is the most significant field: 34,21,13,8,5,3,2,1,1.
  localparam logic [62:0] W_DEF = {7'd34, 7'd21, 7'd13, 7'd8, 7'd5,
                                   7'd3, 7'd2, 7'd1, 7'd1};
  // Lane 5 weight 0.
  localparam logic [62:0] W_Z5  = {7'd34, 7'd21, 7'd13, 7'd0, 7'd5,
                                   7'd3, 7'd2, 7'd1, 7'd1};
  // Lanes 0/1 weight fields hold junk, which the encoder must ignore.
  localparam logic [62:0] W_J01 = {7'd34, 7'd21, 7'd13, 7'd8, 7'd5,
                                   7'd3, 7'd2, 7'd63, 7'd63};

  always #5 clk = ~clk;

  fns_enc_7_2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .en_flag   (en_flag),
    .weights   (weights),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .codeout   (codeout),
    .err       (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one word through the encoder. The inputs are scrambled after the
  // accept edge, DONE is held for 'hold' cycles while a competing word is
  // offered, and then the output handshake is completed.
  task automatic encode(input string name, input logic [6:0] d,
                        input logic [8:0] en, input logic [62:0] w,
                        input logic [8:0] exp_code, input logic exp_err,
                        input int hold);
    int cyc;
    logic [8:0] held_code;
    check({name, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    data_in  = d;
    en_flag  = en;
    weights  = w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    data_in  = ~d;
    en_flag  = ~en;
    weights  = ~w;
    check({name, ".in_ready_run"}, 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check({name, ".latency"}, 32'(cyc), 32'd9);
    held_code = codeout;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      data_in  = 7'h55;
      step();
      check({name, ".bp_out_valid"}, 32'(out_valid), 32'd1);
      check({name, ".bp_in_ready"}, 32'(in_ready), 32'd0);
      check({name, ".bp_code_stable"}, 32'(codeout), 32'(held_code));
    end
    in_valid = 1'b0;
    check({name, ".codeout"}, 32'(codeout), 32'(exp_code));
    check({name, ".err"}, 32'(err), 32'(exp_err));
    $display("txn %s: data=%0d en=%03h code=%03h err=%0b latency=%0d hold=%0d",
             name, d, en, codeout, err, cyc, hold);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, ".post_out_valid"}, 32'(out_valid), 32'd0);
    check({name, ".post_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    en_flag   = 9'h1FF;
    weights   = W_DEF;
    out_ready = 1'b0;
    step();
    step();
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.codeout", 32'(codeout), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    rst_n = 1'b1;
    step();

    encode("zero",  7'd0,   9'h1FF, W_DEF, 9'h000, 1'b0, 0);
    encode("d50",   7'd50,  9'h1FF, W_DEF, 9'h148, 1'b0, 0);
    encode("d88",   7'd88,  9'h1FF, W_DEF, 9'h1FF, 1'b0, 0);
    encode("d100",  7'd100, 9'h1FF, W_DEF, 9'h1FF, 1'b1, 0);
    encode("en0FF", 7'd40,  9'h0FF, W_DEF, 9'h0D2, 1'b0, 0);
    encode("bp50",  7'd50,  9'h1FF, W_DEF, 9'h148, 1'b0, 5);
    // The word right after backpressure must still be accepted.
    encode("after_bp", 7'd88, 9'h1FF, W_DEF, 9'h1FF, 1'b0, 0);
    encode("w0lane5", 7'd0, 9'h1FF, W_Z5,  9'h020, 1'b0, 0);
    encode("junk01",  7'd1, 9'h1FF, W_J01, 9'h002, 1'b0, 0);

    // Reset while lane 4 is being processed (four RUN edges after accept).
    data_in  = 7'd100;
    en_flag  = 9'h1FF;
    weights  = W_DEF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst.in_ready", 32'(in_ready), 32'd1);
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.codeout", 32'(codeout), 32'd0);
    check("midrst.err", 32'(err), 32'd0);
    $display("txn midrst: reset in RUN, in_ready=%0b out_valid=%0b code=%03h",
             in_ready, out_valid, codeout);
    for (int i = 0; i < 12; i++) step();
    check("midrst.no_output", 32'(out_valid), 32'd0);
    encode("fresh50", 7'd50, 9'h1FF, W_DEF, 9'h148, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
